// File: rtl/exp5_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exp5_pkg
// Description : Shared state encoding for the exp5_uc control unit.
//               The debug codes are the values driven on db_estado.
// Revision    : 1.0 - initial release
// ============================================================================
package exp5_pkg;

    localparam logic [3:0] DB_INICIAL     = 4'd0;
    localparam logic [3:0] DB_PREPARACAO  = 4'd1;
    localparam logic [3:0] DB_ESPERA_SEG  = 4'd2;
    localparam logic [3:0] DB_MEDIR       = 4'd3;
    localparam logic [3:0] DB_AGUARDA_MED = 4'd4;
    localparam logic [3:0] DB_TRANSMITE   = 4'd5;
    localparam logic [3:0] DB_AGUARDA_TX  = 4'd6;
    localparam logic [3:0] DB_PROXIMO     = 4'd7;
    localparam logic [3:0] DB_FINAL       = 4'd8;
    localparam logic [3:0] DB_ERRO        = 4'd14;

    typedef enum logic [3:0] {
        INICIAL     = DB_INICIAL,
        PREPARACAO  = DB_PREPARACAO,
        ESPERA_SEG  = DB_ESPERA_SEG,
        MEDIR       = DB_MEDIR,
        AGUARDA_MED = DB_AGUARDA_MED,
        TRANSMITE   = DB_TRANSMITE,
        AGUARDA_TX  = DB_AGUARDA_TX,
        PROXIMO     = DB_PROXIMO,
        FINAL       = DB_FINAL,
        ERRO        = DB_ERRO
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/exp5_uc_timeout.sv
`default_nettype none
// ============================================================================
// Module      : exp5_uc_timeout
// Description : Measurement watchdog. Saturating counter cleared on request,
//               counting while enabled; o_estouro flags that the counter has
//               reached TIMEOUT_CICLOS-1.
// Revision    : 1.0 - initial release
// ============================================================================
module exp5_uc_timeout #(
    parameter int TIMEOUT_CICLOS = 2_500_000,
    parameter int TW             = $clog2(TIMEOUT_CICLOS + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_estouro
);

    localparam logic [TW-1:0] c_limite = TW'(TIMEOUT_CICLOS - 1);

    logic [TW-1:0] r_contagem;

    // Count enabled cycles, holding at the limit so the flag stays asserted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_contagem <= '0;
        end else if (i_clear) begin
            r_contagem <= '0;
        end else if (i_enable && (r_contagem != c_limite)) begin
            r_contagem <= r_contagem + TW'(1);
        end
    end

    assign o_estouro = (r_contagem == c_limite);

endmodule
`default_nettype wire

// File: rtl/exp5_uc.sv
`default_nettype none
// ============================================================================
// Module      : exp5_uc
// Description : Control unit for the ultrasonic measurement + 7E1 serial
//               datapath. Once per second: request a measurement, then send
//               hundreds/tens/units and '#'. Moore FSM, strobes decoded from
//               the state register.
//               Optional watchdog compiled in with EXP5_UC_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module exp5_uc
    import exp5_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 2_500_000,
    parameter int TW             = $clog2(TIMEOUT_CICLOS + 1)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       um_segundo,
    input  logic       pronto_medida,
    input  logic       pronto_transmissao,
    input  logic       fim_serial,
    output logic       zera,
    output logic       medir,
    output logic       partida_serial,
    output logic       conta_ascii,
    output logic       pronto,
    output logic       erro,
    output logic [3:0] db_estado
);

    estado_t r_estado;
    estado_t w_proximo;
    logic    w_estouro;

`ifdef EXP5_UC_WATCHDOG_EN
    logic w_wd_clear;
    logic w_wd_enable;
    logic r_erro;

    assign w_wd_clear  = (r_estado == MEDIR);
    assign w_wd_enable = (r_estado == AGUARDA_MED);

    exp5_uc_timeout #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
        .TW             (TW)
    ) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_estouro (w_estouro)
    );

    // Sticky error: a valid measurement clears it, and wins over a
    // simultaneous timeout
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_erro <= 1'b0;
        end else if (r_estado == AGUARDA_MED) begin
            if (pronto_medida) begin
                r_erro <= 1'b0;
            end else if (w_estouro) begin
                r_erro <= 1'b1;
            end
        end
    end

    assign erro = r_erro;
`else
    logic w_unused_params;

    // Without the watchdog the block waits for the echo indefinitely
    assign w_estouro       = 1'b0;
    assign erro            = 1'b0;
    assign w_unused_params = ^{TIMEOUT_CICLOS, TW};
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // Next-state logic and Moore strobe decode
    always_comb begin
        w_proximo      = r_estado;
        zera           = 1'b0;
        medir          = 1'b0;
        partida_serial = 1'b0;
        conta_ascii    = 1'b0;
        pronto         = 1'b0;
        db_estado      = r_estado;
        case (r_estado)
            INICIAL: begin
                if (ligar) begin
                    w_proximo = PREPARACAO;
                end
            end
            PREPARACAO: begin
                zera      = 1'b1;
                w_proximo = ESPERA_SEG;
            end
            ESPERA_SEG: begin
                if (um_segundo) begin
                    w_proximo = MEDIR;
                end
            end
            MEDIR: begin
                medir     = 1'b1;
                w_proximo = AGUARDA_MED;
            end
            AGUARDA_MED: begin
                if (pronto_medida) begin
                    w_proximo = TRANSMITE;
                end else if (w_estouro) begin
                    w_proximo = ERRO;
                end
            end
            TRANSMITE: begin
                partida_serial = 1'b1;
                w_proximo      = AGUARDA_TX;
            end
            AGUARDA_TX: begin
                if (pronto_transmissao) begin
                    w_proximo = fim_serial ? FINAL : PROXIMO;
                end
            end
            PROXIMO: begin
                conta_ascii = 1'b1;
                w_proximo   = TRANSMITE;
            end
            FINAL: begin
                pronto    = 1'b1;
                w_proximo = ligar ? PREPARACAO : INICIAL;
            end
            ERRO: begin
                w_proximo = ligar ? PREPARACAO : INICIAL;
            end
            default: begin
                w_proximo = INICIAL;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_exp5_uc.sv
`default_nettype none
// ============================================================================
// Module      : tb_exp5_uc
// Description : Self-checking bench for exp5_uc. The bench plays the
//               datapath (1 s timer, sonar, serial TX, character selector)
//               with random latencies and checks strobe timing against the
//               cycle relations of the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exp5_uc;

    localparam int TO = 100;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ligar = 1'b0;
    logic       um_segundo = 1'b0;
    logic       pronto_medida = 1'b0;
    logic       pronto_transmissao = 1'b0;
    logic       fim_serial = 1'b0;
    logic       zera;
    logic       medir;
    logic       partida_serial;
    logic       conta_ascii;
    logic       pronto;
    logic       erro;
    logic [3:0] db_estado;

    exp5_uc #(.TIMEOUT_CICLOS(TO)) dut (
        .clock              (clock),
        .reset              (reset),
        .ligar              (ligar),
        .um_segundo         (um_segundo),
        .pronto_medida      (pronto_medida),
        .pronto_transmissao (pronto_transmissao),
        .fim_serial         (fim_serial),
        .zera               (zera),
        .medir              (medir),
        .partida_serial     (partida_serial),
        .conta_ascii        (conta_ascii),
        .pronto             (pronto),
        .erro               (erro),
        .db_estado          (db_estado)
    );

    always #5 clock = ~clock;

    int n_chk    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int exp_zera = -1;
    int sel      = 0;
    bit m_erro   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
    endtask

    function automatic logic [31:0] outs();
        return {22'd0, zera, medir, partida_serial, conta_ascii, pronto, erro, db_estado};
    endfunction

    // One measurement cycle, from zera to pronto / ERRO / forced reset.
    // Delays are counted from the triggering strobe; -1 disables a response.
    task automatic run_round(input int seg_dly, input int med_dly, input int tx_dly,
                             input int drop_frame, input int rst_frame, input bit expect_to);
        int t_zera = -1, t_u = -1, t_medir = -1, t_part = -1;
        int frames = 0, n_conta = 0, n_zera = 0, n_medir = 0;
        int exp_part = -1, exp_conta = -1, exp_pronto = -1;
        int start;
        bit done = 1'b0, aborted = 1'b0, rst_pending = 1'b0;
        start = cyc;
        while (!done && (cyc - start) < 5000) begin
            tick();
            pronto_medida      = 1'b0;
            pronto_transmissao = 1'b0;
            if (zera) begin
                n_zera++;
                chk("zera_time", cyc, exp_zera);
                chk("zera_state", {28'd0, db_estado}, 1);
                t_zera = cyc; sel = 0; um_segundo = 1'b0;
            end
            if (t_zera >= 0 && t_u < 0 && cyc == t_zera + seg_dly) begin
                um_segundo = 1'b1; t_u = cyc;
            end
            if (medir) begin
                n_medir++;
                chk("medir_time", cyc, t_u + 1);
                chk("medir_state", {28'd0, db_estado}, 3);
                chk("medir_erro", {31'd0, erro}, {31'd0, m_erro});
                t_medir = cyc;
            end
            if (t_medir >= 0 && med_dly >= 0 && cyc == t_medir + med_dly) begin
                pronto_medida = 1'b1; exp_part = cyc + 1; m_erro = 1'b0;
            end
            if (expect_to && t_medir >= 0) begin
                if (cyc == t_medir + TO) chk("to_wait_state", {28'd0, db_estado}, 4);
                if (cyc == t_medir + TO + 1) begin
                    m_erro = 1'b1;
                    chk("to_state", {28'd0, db_estado}, 14);
                    chk("to_erro", {31'd0, erro}, {31'd0, m_erro});
                    done = 1'b1;
                end
            end
            if (partida_serial) begin
                frames++;
                chk("part_time", cyc, exp_part);
                chk("part_state", {28'd0, db_estado}, 5);
                chk("part_erro", {31'd0, erro}, {31'd0, m_erro});
                t_part = cyc;
                if (frames == drop_frame) ligar = 1'b0;
                if (frames == rst_frame) rst_pending = 1'b1;
            end
            if (t_part >= 0 && cyc == t_part + tx_dly) begin
                pronto_transmissao = 1'b1;
                if (sel == 3) exp_pronto = cyc + 1;
                else          exp_conta  = cyc + 1;
                exp_part = cyc + 2;
            end
            if (conta_ascii) begin
                n_conta++;
                chk("conta_time", cyc, exp_conta);
                sel++;
            end
            fim_serial = (sel == 3);
            if (pronto) begin
                chk("pronto_time", cyc, exp_pronto);
                chk("pronto_state", {28'd0, db_estado}, 8);
                done = 1'b1;
            end
            if (rst_pending) begin
                tick();
                chk("pre_rst_state", {28'd0, db_estado}, 6);
                #2 reset = 1'b0;
                ligar = 1'b0;
                #1 chk("rst_async_outs", outs(), 0);
                m_erro = 1'b0;
                aborted = 1'b1;
                done = 1'b1;
            end
        end
        pronto_medida      = 1'b0;
        pronto_transmissao = 1'b0;
        chk("round_done", {31'd0, done}, 1);
        if (!aborted) begin
            chk("n_zera", n_zera, 1);
            chk("n_medir", n_medir, 1);
            chk("n_frames", frames, expect_to ? 0 : 4);
            chk("n_conta", n_conta, expect_to ? 0 : 3);
            exp_zera = ligar ? cyc + 1 : -1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        repeat (3) tick();
        chk("reset_outs", outs(), 0);
        reset = 1'b1;
        tick();
        chk("idle_state", {28'd0, db_estado}, 0);
        tick();
        chk("idle_hold_outs", outs(), 0);

        ligar = 1'b1;
        exp_zera = cyc + 1;
        run_round(10, 20, 30, -1, -1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            run_round(int'($urandom_range(1, 20)), int'($urandom_range(1, 60)),
                      int'($urandom_range(1, 40)), -1, -1, 1'b0);
        end

`ifdef EXP5_UC_WATCHDOG_EN
        run_round(5, -1, 10, -1, -1, 1'b1);
        run_round(5, 30, 10, -1, -1, 1'b0);
`endif

        // echo arrives on the very cycle the watchdog would expire
        run_round(3, TO, 5, -1, -1, 1'b0);

        // ligar dropped during the 2nd frame: the cycle still completes
        run_round(4, 15, 12, 2, -1, 1'b0);
        tick();
        chk("drop_idle_outs", outs(), 0);
        tick();
        chk("drop_idle_hold", {28'd0, db_estado}, 0);

        // asynchronous reset while waiting for the 2nd frame
        ligar = 1'b1;
        exp_zera = cyc + 1;
        run_round(3, 10, 20, -1, 2, 1'b0);
        tick();
        chk("rst_hold_outs", outs(), 0);
        um_segundo = 1'b0;
        fim_serial = 1'b0;
        reset = 1'b1;
        tick();
        chk("post_rst_state", {28'd0, db_estado}, 0);

`ifndef EXP5_UC_WATCHDOG_EN
        begin
            int  bad  = 0;
            bit  seen = 1'b0;
            ligar = 1'b1;
            for (int k = 0; k < 100 && !seen; k++) begin
                tick();
                if (zera) um_segundo = 1'b1;
                if (medir) seen = 1'b1;
            end
            chk("hang_medir_seen", {31'd0, seen}, 1);
            ligar = 1'b0;
            for (int k = 0; k < 10000; k++) begin
                tick();
                if (db_estado !== 4'd4 || erro !== 1'b0 || partida_serial !== 1'b0) bad++;
            end
            chk("hang_bad_cycles", bad, 0);
            chk("hang_state", {28'd0, db_estado}, 4);
            chk("hang_erro", {31'd0, erro}, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
